// File: rtl/mac_tx.sv
// -----------------------------------------------------------------------------
// mac_tx -- GMII transmit MAC for one frame at a time.
//
// Handshakes a frame request from the IP layer, then emits preamble, SFD,
// the frame bytes, zero padding up to MIN_FRAME, and a CRC-32 FCS (LSB
// first), followed by an inter-frame gap. Frames longer than MAX_FRAME are
// truncated (with an FCS over what was sent); a missing ip_tx_ready aborts
// the frame before anything is transmitted. Both cases pulse tx_frame_err.
//
// Ports
//   clk, rstn      : clock, asynchronous active-low reset
//   ip_tx_req      : level request for a frame
//   ip_tx_ready    : IP layer has frame data available
//   ip_tx_data     : frame byte, valid the cycle after mac_data_req
//   ip_tx_end      : marks the last frame byte on ip_tx_data
//   mac_tx_ack     : one-cycle grant of ip_tx_req
//   mac_data_req   : byte request (combinational)
//   mac_send_end   : one-cycle pulse when the frame (incl. IFG) completes
//   gmii_tx_en     : registered GMII transmit enable
//   gmii_txd       : registered GMII transmit data (0x00 when disabled)
//   tx_frame_err   : one-cycle pulse on ready timeout or truncation
// -----------------------------------------------------------------------------
module mac_tx #(
   parameter int IFG_BYTES   = 12,
   parameter int MIN_FRAME   = 60,
   parameter int MAX_FRAME   = 1514,
   parameter int RDY_TIMEOUT = 1023
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       ip_tx_req,
   input  logic       ip_tx_ready,
   input  logic [7:0] ip_tx_data,
   input  logic       ip_tx_end,
   output logic       mac_tx_ack,
   output logic       mac_data_req,
   output logic       mac_send_end,
   output logic       gmii_tx_en,
   output logic [7:0] gmii_txd,
   output logic       tx_frame_err
);

   typedef enum logic [3:0] {
      S_IDLE, S_ACK, S_WAIT_RDY, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
   } state_t;

   state_t      r_state;
   state_t      w_next;

   // r_cnt times the fixed-length phases (WAIT_RDY, PRE, FCS, IFG) and
   // restarts from zero on every state change.
   logic [15:0] r_cnt;
   logic [10:0] r_byte_cnt;   // bytes sent so far in DATA + PAD
   logic [31:0] r_crc;

   logic        w_at_max;
   logic        w_need_pad;
   logic [31:0] w_fcs;
   logic        w_tx_en;
   logic [7:0]  w_tx_byte;
   logic        w_crc_en;

   assign w_at_max   = (r_byte_cnt == 11'(MAX_FRAME - 1));
   // The current DATA byte is not yet counted, hence the +1.
   assign w_need_pad = ((r_byte_cnt + 11'd1) < 11'(MIN_FRAME));
   assign w_fcs      = ~r_crc;

   // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte per call.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  d);
      logic [31:0] c;
      c = crc ^ {24'd0, d};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      return c;
   endfunction

   // ---------------------------------------------------------------- state
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // ----------------------------------------------------------- next state
   // NOTE: defaulting w_next before the case keeps every path assigned, so
   // no latch is inferred.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (ip_tx_req) w_next = S_ACK;
         S_ACK:      w_next = S_WAIT_RDY;
         S_WAIT_RDY: if (ip_tx_ready)                        w_next = S_PRE;
                     else if (r_cnt == 16'(RDY_TIMEOUT))     w_next = S_IDLE;
         S_PRE:      if (r_cnt == 16'd6) w_next = S_SFD;
         S_SFD:      w_next = S_DATA;
         S_DATA:     if (ip_tx_end || w_at_max)
                        w_next = w_need_pad ? S_PAD : S_FCS;
         S_PAD:      if (r_byte_cnt == 11'(MIN_FRAME - 1)) w_next = S_FCS;
         S_FCS:      if (r_cnt == 16'd3) w_next = S_IFG;
         S_IFG:      if (r_cnt == 16'(IFG_BYTES - 1)) w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------- outputs
   always_comb begin
      mac_tx_ack   = 1'b0;
      mac_data_req = 1'b0;
      tx_frame_err = 1'b0;
      w_tx_en      = 1'b0;
      w_tx_byte    = 8'h00;
      w_crc_en     = 1'b0;
      case (r_state)
         S_ACK:      mac_tx_ack = 1'b1;
         S_WAIT_RDY: tx_frame_err = !ip_tx_ready && (r_cnt == 16'(RDY_TIMEOUT));
         S_PRE: begin
            w_tx_en   = 1'b1;
            w_tx_byte = 8'h55;
         end
         S_SFD: begin
            w_tx_en      = 1'b1;
            w_tx_byte    = 8'hD5;
            mac_data_req = 1'b1;   // first frame byte arrives in DATA
         end
         S_DATA: begin
            w_tx_en      = 1'b1;
            w_tx_byte    = ip_tx_data;
            w_crc_en     = 1'b1;
            mac_data_req = !ip_tx_end;
            tx_frame_err = !ip_tx_end && w_at_max;
         end
         S_PAD: begin
            w_tx_en  = 1'b1;
            w_crc_en = 1'b1;
         end
         S_FCS: begin
            w_tx_en   = 1'b1;
            w_tx_byte = w_fcs[8*r_cnt[1:0] +: 8];
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt        <= '0;
         r_byte_cnt   <= '0;
         r_crc        <= '0;
         gmii_tx_en   <= 1'b0;
         gmii_txd     <= 8'h00;
         mac_send_end <= 1'b0;
      end else begin
         r_cnt <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;

         if (r_state == S_SFD) begin
            r_byte_cnt <= '0;
            r_crc      <= 32'hFFFF_FFFF;
         end else if (w_crc_en) begin
            r_byte_cnt <= r_byte_cnt + 11'd1;
            r_crc      <= crc32_byte(r_crc, w_tx_byte);
         end

         gmii_tx_en   <= w_tx_en;
         gmii_txd     <= w_tx_byte;   // already 0x00 whenever w_tx_en is low
         mac_send_end <= (r_state == S_IFG) && (w_next == S_IDLE);
      end
   end

endmodule

// File: tb/tb_mac_tx.sv
// -----------------------------------------------------------------------------
// tb_mac_tx -- self-checking bench for mac_tx.
//
// Frames of random content are fed through an IP-layer byte source; a
// monitor records every GMII byte and every ack/send_end/error pulse with a
// cycle stamp. Expected wire bytes come from a reference model that builds
// the whole frame (preamble, SFD, data, pad, table-driven CRC-32 FCS).
// -----------------------------------------------------------------------------
module tb_mac_tx;

   localparam int IFG_BYTES   = 12;
   localparam int MIN_FRAME   = 60;
   localparam int MAX_FRAME   = 1514;
   localparam int RDY_TIMEOUT = 1023;

   logic       clk = 1'b0;
   logic       rstn;
   logic       ip_tx_req;
   logic       ip_tx_ready;
   logic [7:0] ip_tx_data;
   logic       ip_tx_end;
   logic       mac_tx_ack;
   logic       mac_data_req;
   logic       mac_send_end;
   logic       gmii_tx_en;
   logic [7:0] gmii_txd;
   logic       tx_frame_err;

   mac_tx #(
      .IFG_BYTES  (IFG_BYTES),
      .MIN_FRAME  (MIN_FRAME),
      .MAX_FRAME  (MAX_FRAME),
      .RDY_TIMEOUT(RDY_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .ip_tx_req   (ip_tx_req),
      .ip_tx_ready (ip_tx_ready),
      .ip_tx_data  (ip_tx_data),
      .ip_tx_end   (ip_tx_end),
      .mac_tx_ack  (mac_tx_ack),
      .mac_data_req(mac_data_req),
      .mac_send_end(mac_send_end),
      .gmii_tx_en  (gmii_tx_en),
      .gmii_txd    (gmii_txd),
      .tx_frame_err(tx_frame_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------------- monitor
   int         cyc = 0;
   int         idle_bad = 0;
   logic [7:0] tx_q[$];
   int         tx_cyc[$];
   int         ack_q[$];
   int         end_q[$];
   int         err_q[$];

   always @(negedge clk) begin
      cyc++;
      if (gmii_tx_en === 1'b1) begin
         tx_q.push_back(gmii_txd);
         tx_cyc.push_back(cyc);
      end else if (gmii_txd !== 8'h00) begin
         idle_bad++;
      end
      if (mac_tx_ack === 1'b1)   ack_q.push_back(cyc);
      if (mac_send_end === 1'b1) end_q.push_back(cyc);
      if (tx_frame_err === 1'b1) err_q.push_back(cyc);
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------- IP source + model
   logic [7:0]  payload[0:2047];
   int          plen = 0;
   bit          end_en = 1'b1;
   int          idx = 0;
   bit          req_seen = 1'b0;
   logic [31:0] crc_tab[0:255];
   logic [7:0]  exp_q[$];

   // One clock: drive inputs just after the rising edge, sample at the
   // falling edge, then let the monitor settle.
   task automatic step();
      @(posedge clk); #1;
      if (req_seen && idx < plen) begin
         ip_tx_data = payload[idx];
         ip_tx_end  = end_en && (idx == plen - 1);
         idx++;
      end else begin
         ip_tx_data = 8'($urandom);
         ip_tx_end  = 1'b0;
      end
      @(negedge clk);
      req_seen = mac_data_req;
      if (mac_tx_ack) idx = 0;
      #1;
   endtask

   task automatic build_table();
      logic [31:0] c;
      for (int n = 0; n < 256; n++) begin
         c = 32'(n);
         for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         crc_tab[n] = c;
      end
   endtask

   // Full on-the-wire image of a frame whose source offers len bytes.
   task automatic build_expected(input int len);
      logic [31:0] crc;
      logic [7:0]  b;
      int          n;
      int          total;
      exp_q.delete();
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      n     = (len > MAX_FRAME) ? MAX_FRAME : len;
      total = (n < MIN_FRAME) ? MIN_FRAME : n;
      crc   = 32'hFFFF_FFFF;
      for (int i = 0; i < total; i++) begin
         b = (i < n) ? payload[i] : 8'h00;
         exp_q.push_back(b);
         crc = crc_tab[crc[7:0] ^ b] ^ (crc >> 8);
      end
      crc = ~crc;
      for (int k = 0; k < 4; k++) exp_q.push_back(crc[8*k +: 8]);
   endtask

   task automatic fill_payload(input int len, input bit with_end);
      for (int i = 0; i < len; i++) payload[i] = 8'($urandom);
      plen   = len;
      end_en = with_end;
   endtask

   // Compare captured bytes from b_tx against reps copies of exp_q.
   task automatic check_bytes(input string tag, input int b_tx, input int reps);
      int n;
      int bad;
      int e;
      n   = tx_q.size() - b_tx;
      e   = exp_q.size();
      bad = 0;
      check({tag, "_len"}, n, e * reps);
      for (int i = 0; i < n && i < e * reps; i++)
         if (tx_q[b_tx + i] !== exp_q[i % e]) bad++;
      check({tag, "_bytes_bad"}, bad, 0);
      if (n >= 4)
         for (int k = 0; k < 4; k++)
            check({tag, "_fcs"}, tx_q[b_tx + n - 4 + k], exp_q[e - 4 + k]);
   endtask

   task automatic do_frame(input string tag, input int len, input bit with_end);
      int b_tx, b_end, b_err, b_ack, guard, n, last;
      b_tx  = tx_q.size();
      b_end = end_q.size();
      b_err = err_q.size();
      b_ack = ack_q.size();
      fill_payload(len, with_end);
      build_expected(len);
      ip_tx_req   = 1'b1;
      ip_tx_ready = 1'b0;
      guard = 0;
      while (ack_q.size() == b_ack && guard < 50) begin step(); guard++; end
      ip_tx_req = 1'b0;
      repeat ($urandom_range(0, 6)) step();
      ip_tx_ready = 1'b1;
      guard = 0;
      while (end_q.size() == b_end && guard < 4000) begin
         step();
         guard++;
         // Once transmitting, req/ready wiggle freely; req is dropped well
         // before the frame returns to idle.
         if (gmii_tx_en && (tx_q.size() - b_tx) < exp_q.size() - 2) begin
            ip_tx_ready = 1'($urandom);
            ip_tx_req   = 1'($urandom);
         end else if (gmii_tx_en) begin
            ip_tx_req = 1'b0;
         end
      end
      ip_tx_req   = 1'b0;
      ip_tx_ready = 1'b0;
      repeat (4) step();

      n = tx_q.size() - b_tx;
      check({tag, "_acks"}, ack_q.size() - b_ack, 1);
      check({tag, "_send_end"}, end_q.size() - b_end, 1);
      check({tag, "_err"}, err_q.size() - b_err, (len > MAX_FRAME) ? 1 : 0);
      check_bytes(tag, b_tx, 1);
      if (n > 0) begin
         last = tx_q.size() - 1;
         check({tag, "_tx_en_span"}, tx_cyc[last] - tx_cyc[b_tx] + 1, exp_q.size());
         if (end_q.size() > b_end)
            check({tag, "_ifg"}, end_q[b_end] - tx_cyc[last], IFG_BYTES);
      end
   endtask

   // ----------------------------------------------------------------- main
   initial begin
      int b_tx, b_end, b_err, b_ack, guard, gap;
      build_table();
      rstn        = 1'b0;
      ip_tx_req   = 1'b0;
      ip_tx_ready = 1'b0;
      ip_tx_data  = 8'h00;
      ip_tx_end   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_en",    gmii_tx_en,   0);
      check("rst_txd",      gmii_txd,     0);
      check("rst_ack",      mac_tx_ack,   0);
      check("rst_data_req", mac_data_req, 0);
      check("rst_send_end", mac_send_end, 0);
      check("rst_err",      tx_frame_err, 0);
      #2 rstn = 1'b1;
      repeat (3) step();

      // Padding, exact-minimum, no-pad and random-length frames.
      do_frame("f42", 42, 1'b1);
      do_frame("f100", 100, 1'b1);
      do_frame("f60", 60, 1'b1);
      do_frame("f59", 59, 1'b1);
      do_frame("f1", 1, 1'b1);
      for (int r = 0; r < 4; r++) do_frame("frand", $urandom_range(1, 200), 1'b1);

      // Request held high across two frames.
      b_tx  = tx_q.size();
      b_end = end_q.size();
      b_ack = ack_q.size();
      fill_payload(42, 1'b1);
      build_expected(42);
      ip_tx_req   = 1'b1;
      ip_tx_ready = 1'b1;
      guard = 0;
      while (end_q.size() - b_end < 2 && guard < 500) begin step(); guard++; end
      ip_tx_req   = 1'b0;
      ip_tx_ready = 1'b0;
      repeat (4) step();
      check("hold_acks", ack_q.size() - b_ack, 2);
      check("hold_send_end", end_q.size() - b_end, 2);
      check_bytes("hold", b_tx, 2);
      if (tx_q.size() - b_tx == 2 * exp_q.size()) begin
         gap = tx_cyc[b_tx + exp_q.size()] - tx_cyc[b_tx + exp_q.size() - 1] - 1;
         check("hold_gap_ge_ifg", gap >= IFG_BYTES, 1);
      end
      if (ack_q.size() - b_ack >= 2 && end_q.size() > b_end)
         check("hold_ack_after_end", ack_q[b_ack + 1] > end_q[b_end], 1);

      // ip_tx_ready never arrives.
      b_tx  = tx_q.size();
      b_end = end_q.size();
      b_err = err_q.size();
      b_ack = ack_q.size();
      plen  = 0;
      ip_tx_req = 1'b1;
      guard = 0;
      while (ack_q.size() == b_ack && guard < 50) begin step(); guard++; end
      ip_tx_req = 1'b0;
      guard = 0;
      while (err_q.size() == b_err && guard < 1100) begin step(); guard++; end
      repeat (40) step();
      check("to_err_count", err_q.size() - b_err, 1);
      if (err_q.size() > b_err && ack_q.size() > b_ack)
         check("to_err_cycle", err_q[b_err] - ack_q[b_ack], RDY_TIMEOUT + 1);
      check("to_tx_bytes", tx_q.size() - b_tx, 0);
      check("to_send_end", end_q.size() - b_end, 0);

      // ip_tx_end withheld: truncation at MAX_FRAME.
      do_frame("trunc", 1600, 1'b0);

      // Reset in the middle of DATA.
      b_tx  = tx_q.size();
      b_end = end_q.size();
      fill_payload(42, 1'b1);
      ip_tx_req = 1'b1;
      b_ack = ack_q.size();
      guard = 0;
      while (ack_q.size() == b_ack && guard < 50) begin step(); guard++; end
      ip_tx_req   = 1'b0;
      ip_tx_ready = 1'b1;
      guard = 0;
      while (tx_q.size() - b_tx < 8 + 31 && guard < 200) begin step(); guard++; end
      check("mid_tx_en_before", gmii_tx_en, 1);
      #2 rstn = 1'b0;
      #1;
      check("mid_rst_tx_en", gmii_tx_en, 0);
      check("mid_rst_txd", gmii_txd, 0);
      check("mid_rst_data_req", mac_data_req, 0);
      ip_tx_ready = 1'b0;
      req_seen    = 1'b0;
      plen        = 0;
      repeat (3) @(negedge clk);
      #2 rstn = 1'b1;
      repeat (20) step();
      check("mid_rst_no_send_end", end_q.size() - b_end, 0);
      check("mid_rst_tx_stopped", tx_q.size() - b_tx, 8 + 31);
      do_frame("post_rst42", 42, 1'b1);

      check("txd_zero_when_idle", idle_bad, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mac_tx.md
MAC_TX -- requirements
Module: mac_tx

Interface
REQ-001 SHALL have parameter IFG_BYTES, default 12, the number of idle cycles between frames.
REQ-002 SHALL have parameter MIN_FRAME, default 60, the minimum bytes before FCS (header+payload+pad).
REQ-003 SHALL have parameter MAX_FRAME, default 1514, the maximum bytes before FCS.
REQ-004 SHALL have parameter RDY_TIMEOUT, default 1023, the maximum cycles to wait for ip_tx_ready after ack.
REQ-005 SHALL have port clk, in, 1: the single clock; reset is asynchronous and active-low.
REQ-006 SHALL have port rstn, in, 1: asynchronous active-low reset.
REQ-007 SHALL have port ip_tx_req, in, 1: level frame request from the IP layer.
REQ-008 SHALL have port ip_tx_ready, in, 1: IP layer frame data is available.
REQ-009 SHALL have port ip_tx_data, in, 8: frame byte (dest MAC first), valid the cycle after mac_data_req.
REQ-010 SHALL have port ip_tx_end, in, 1: marks the last frame byte on ip_tx_data.
REQ-011 SHALL have port mac_tx_ack, out, 1: one-cycle grant of ip_tx_req.
REQ-012 SHALL have port mac_data_req, out, 1: byte request.
REQ-013 SHALL have port mac_send_end, out, 1: one-cycle pulse at frame completion.
REQ-014 SHALL have port gmii_tx_en, out, 1: registered GMII transmit enable.
REQ-015 SHALL have port gmii_txd, out, 8: registered GMII transmit data.
REQ-016 SHALL have port tx_frame_err, out, 1: one-cycle pulse on timeout or truncation.

Function
REQ-017 SHALL implement states IDLE, ACK, WAIT_RDY, PRE, SFD, DATA, PAD, FCS, IFG.
REQ-018 In IDLE with ip_tx_req=1, SHALL go to ACK; ACK SHALL assert mac_tx_ack for exactly one cycle, then go to WAIT_RDY.
REQ-019 In WAIT_RDY, ip_tx_ready=1 SHALL go to PRE; RDY_TIMEOUT+1 cycles without ready SHALL pulse tx_frame_err and return to IDLE with no transmission and no mac_send_end.
REQ-020 PRE SHALL last 7 cycles emitting 0x55, and SFD SHALL last 1 cycle emitting 0xD5.
REQ-021 mac_data_req SHALL be combinational: 1 in SFD, 1 in DATA while ip_tx_end=0, else 0.
REQ-022 DATA SHALL emit ip_tx_data each cycle and count bytes in 11 bits; the ip_tx_end cycle byte is the last.
REQ-023 After the last byte, count<MIN_FRAME SHALL go to PAD emitting 0x00 until count=MIN_FRAME; otherwise it SHALL go directly to FCS.
REQ-024 If count reaches MAX_FRAME without ip_tx_end, SHALL end DATA, pulse tx_frame_err, and continue to FCS (frame truncated).
REQ-025 CRC-32: polynomial 0x04C11DB7 reflected, init 0xFFFFFFFF, over all DATA and PAD bytes; FCS = bitwise complement, sent in 4 cycles, least-significant byte first.
REQ-026 IFG SHALL hold gmii_tx_en=0 for IFG_BYTES cycles, then return to IDLE, registering mac_send_end=1 for one cycle on that transition.
REQ-027 gmii_tx_en/gmii_txd SHALL be registered: 1 in the cycle after PRE/SFD/DATA/PAD/FCS, 0 otherwise, with gmii_txd=0x00 when disabled.
REQ-028 ip_tx_req held high through IFG SHALL NOT be acked before IDLE; the earliest next ack is the cycle after mac_send_end.
REQ-029 ip_tx_ready/ip_tx_req changes after leaving WAIT_RDY SHALL be ignored.

Reset
REQ-030 rstn=0 SHALL asynchronously force IDLE and clear all outputs, CRC, and counters; gmii_tx_en falls immediately mid-frame and no mac_send_end is produced.

Verification
REQ-031 42-byte frame -> 18 pad bytes 0x00; gmii_tx_en high exactly 72 cycles (8+60+4); mac_send_end 12 cycles after tx_en falls.
REQ-032 100-byte frame -> no pad; tx_en high 112 cycles; FCS bytes match the software CRC-32 model, LSB first.
REQ-033 ip_tx_req held high across 2 frames -> 2 acks, each tx_en gap ≥12 cycles, 2 mac_send_end pulses.
REQ-034 ip_tx_ready never asserted -> tx_frame_err at cycle 1024 after ack; tx_en stays 0; no mac_send_end.
REQ-035 ip_tx_end withheld -> truncated at 1514 bytes, tx_frame_err pulse, valid FCS, tx_en high 1526 cycles.
REQ-036 rstn low during DATA byte 30 -> tx_en 0 immediately; after release, the next request gives a normal 42-byte frame per REQ-031.
